// File: rtl/dbg_wire_pkg.sv
// Shared constants and helpers for the virtual-wire debug probe endpoint.
// Instruction encodings, ASCII tag packing and width arithmetic.
package dbg_wire_pkg;

   localparam logic [1:0] IR_READ_ID      = 2'b00;
   localparam logic [1:0] IR_READ_PROBE   = 2'b01;
   localparam logic [1:0] IR_WRITE_SOURCE = 2'b10;
   localparam logic [1:0] IR_BYPASS       = 2'b11;

   // First character lands in the most significant byte.
   function automatic logic [31:0] pack_id(input logic [7:0] c0, input logic [7:0] c1,
                                           input logic [7:0] c2, input logic [7:0] c3);
      return {c0, c1, c2, c3};
   endfunction

   function automatic int max_w(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/dbg_dr_chain.sv
// Capture/shift data register with a run-time selectable active length.
// Bits at or above the active length hold their value while shifting.
module dbg_dr_chain #(
   parameter int N     = 32,
   parameter int OUT_W = 1,
   parameter int LW    = $clog2(N + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             capture,
   input  logic             shift,
   input  logic [N-1:0]     cap_val,
   input  logic [LW-1:0]    len,
   input  logic             tdi,
   output logic [OUT_W-1:0] dout
);

   logic [N-1:0]  sr;
   logic [N-1:0]  sr_shift;
   logic [N:0]    sr_ext;
   logic [LW-1:0] len_m1;

   assign len_m1 = len - LW'(1);

   always_comb begin
      sr_ext   = {1'b0, sr};
      sr_shift = sr;
      for (int i = 0; i < N; i++) begin
         if (LW'(i) == len_m1)
            sr_shift[i] = tdi;
         else if (LW'(i) < len_m1)
            sr_shift[i] = sr_ext[i+1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         sr <= '0;
      else if (capture)
         sr <= cap_val;
      else if (shift)
         sr <= sr_shift;
   end

   assign dout = sr[OUT_W-1:0];

endmodule

// File: rtl/debug_probe_wire.sv
// Debug probe/source endpoint: scan-readable probe bus and instance tag,
// scan-writable source bus, all in the single fast clock domain.
module debug_probe_wire
   import dbg_wire_pkg::*;
#(
   parameter int          PROBE_WIDTH = 32,
   parameter int          WIDTH       = 0,
   parameter logic [31:0] INSTANCE_ID = pack_id("N", "O", "N", "E")
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [PROBE_WIDTH-1:0]     probe,
   output logic [max_w(WIDTH,1)-1:0]  source,
   input  logic                       sel,
   input  logic [1:0]                 ir_in,
   input  logic                       capture_dr,
   input  logic                       shift_dr,
   input  logic                       update_dr,
   input  logic                       tdi,
   output logic                       tdo
);

   localparam int SW      = max_w(WIDTH, 1);
   localparam int N       = max_w(max_w(PROBE_WIDTH, WIDTH), 32);
   localparam int LW      = $clog2(N + 1);
   localparam bit HAS_SRC = (WIDTH > 0);

   logic [PROBE_WIDTH-1:0] probe_q;
   logic [1:0]             ir_q;
   logic [N-1:0]           cap_val;
   logic [LW-1:0]          len;
   logic [SW-1:0]          dout;
   logic                   cap, sh, upd;

   // Capture outranks shift, which outranks update.
   assign cap = sel & capture_dr;
   assign sh  = sel & shift_dr & ~capture_dr;
   assign upd = sel & update_dr & ~capture_dr & ~shift_dr;

   always_comb begin
      len = LW'(1);
      case (ir_q)
         IR_READ_ID:      len = LW'(32);
         IR_READ_PROBE:   len = LW'(PROBE_WIDTH);
         IR_WRITE_SOURCE: len = LW'(SW);
         default:         len = LW'(1);
      endcase
   end

   always_comb begin
      cap_val = '0;
      case (ir_in)
         IR_READ_ID:      cap_val = N'(INSTANCE_ID);
         IR_READ_PROBE:   cap_val = N'(probe_q);
         IR_WRITE_SOURCE: cap_val = N'(source);
         default:         cap_val = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         probe_q <= '0;
         ir_q    <= IR_READ_ID;
      end else begin
         probe_q <= probe;
         if (cap)
            ir_q <= ir_in;
      end
   end

   // With no source bus this register never leaves its reset value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         source <= '0;
      else if (HAS_SRC && upd && (ir_q == IR_WRITE_SOURCE))
         source <= dout;
   end

   dbg_dr_chain #(.N(N), .OUT_W(SW), .LW(LW)) u_chain (
      .clk     (clk),
      .rst_n   (rst_n),
      .capture (cap),
      .shift   (sh),
      .cap_val (cap_val),
      .len     (len),
      .tdi     (tdi),
      .dout    (dout)
   );

   assign tdo = sel & dout[0];

endmodule

// File: tb/tb_debug_probe_wire.sv
// Directed bench for debug_probe_wire with a 16-bit source and "QONE" tag.
module tb_debug_probe_wire;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] probe;
   logic [15:0] source;
   logic        sel;
   logic [1:0]  ir_in;
   logic        capture_dr, shift_dr, update_dr, tdi;
   logic        tdo;

   int n_tests = 0;
   int n_fail  = 0;

   localparam logic [31:0] ID_QONE = 32'h514F4E45;

   debug_probe_wire #(.PROBE_WIDTH(32), .WIDTH(16), .INSTANCE_ID("QONE")) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .probe      (probe),
      .source     (source),
      .sel        (sel),
      .ir_in      (ir_in),
      .capture_dr (capture_dr),
      .shift_dr   (shift_dr),
      .update_dr  (update_dr),
      .tdi        (tdi),
      .tdo        (tdo)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_capture(input logic [1:0] ir);
      ir_in      = ir;
      capture_dr = 1'b1;
      tick();
      capture_dr = 1'b0;
   endtask

   // Reads tdo before each shift edge, so bit i of dout is the i-th bit out.
   task automatic shift_bits(input int n, input logic [63:0] din, output logic [63:0] dout);
      dout = '0;
      for (int i = 0; i < n; i++) begin
         dout[i]  = tdo;
         tdi      = din[i];
         shift_dr = 1'b1;
         tick();
      end
      shift_dr = 1'b0;
      tdi      = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) tick();
      n_tests++;
      if (tdo !== 1'b0 || source !== 16'h0) begin
         n_fail++;
         $display("FAIL reset: tdo=%b source=%h, want 0/0000", tdo, source);
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_read_id();
      logic [63:0] d;
      do_capture(2'b00);
      n_tests++;
      if (tdo !== 1'b1) begin
         n_fail++;
         $display("FAIL read_id_first_bit: tdo=%b want 1", tdo);
      end
      shift_bits(32, 64'h0, d);
      n_tests++;
      if (d[31:0] !== ID_QONE) begin
         n_fail++;
         $display("FAIL read_id: got %h want %h", d[31:0], ID_QONE);
      end
   endtask

   task automatic test_read_probe();
      logic [63:0] d;
      probe = 32'h001D8340;
      tick();
      tick();
      do_capture(2'b01);
      probe = 32'hFFFFFFFF;
      shift_bits(32, 64'h0, d);
      n_tests++;
      if (d[31:0] !== 32'h001D8340) begin
         n_fail++;
         $display("FAIL read_probe: got %h want 001d8340", d[31:0]);
      end
   endtask

   task automatic test_write_source();
      logic [63:0] d;
      do_capture(2'b10);
      shift_bits(16, 64'h3B06, d);
      n_tests++;
      if (d[15:0] !== 16'h0000) begin
         n_fail++;
         $display("FAIL write_old_source: got %h want 0000", d[15:0]);
      end
      n_tests++;
      if (source !== 16'h0000) begin
         n_fail++;
         $display("FAIL write_before_update: source=%h want 0000", source);
      end
      update_dr = 1'b1;
      tick();
      update_dr = 1'b0;
      n_tests++;
      if (source !== 16'h3B06) begin
         n_fail++;
         $display("FAIL write_update: source=%h want 3b06", source);
      end
      do_capture(2'b10);
      shift_bits(16, 64'h0, d);
      n_tests++;
      if (d[15:0] !== 16'h3B06) begin
         n_fail++;
         $display("FAIL write_readback: got %h want 3b06", d[15:0]);
      end
   endtask

   task automatic test_sel_low();
      logic [63:0] d;
      do_capture(2'b10);
      shift_bits(16, 64'hA5A5, d);
      sel        = 1'b0;
      ir_in      = 2'b00;
      capture_dr = 1'b1;
      tick();
      capture_dr = 1'b0;
      n_tests++;
      if (tdo !== 1'b0) begin
         n_fail++;
         $display("FAIL sel_low_tdo: tdo=%b want 0", tdo);
      end
      tdi      = 1'b1;
      shift_dr = 1'b1;
      tick();
      shift_dr  = 1'b0;
      tdi       = 1'b0;
      update_dr = 1'b1;
      tick();
      update_dr = 1'b0;
      n_tests++;
      if (source !== 16'h3B06) begin
         n_fail++;
         $display("FAIL sel_low_source: source=%h want 3b06", source);
      end
      sel = 1'b1;
      #1;
      shift_bits(16, 64'h0, d);
      n_tests++;
      if (d[15:0] !== 16'hA5A5) begin
         n_fail++;
         $display("FAIL sel_low_sr: got %h want a5a5", d[15:0]);
      end
   endtask

   task automatic test_cap_shift_same();
      logic [63:0] d;
      ir_in      = 2'b00;
      capture_dr = 1'b1;
      shift_dr   = 1'b1;
      tdi        = 1'b0;
      tick();
      capture_dr = 1'b0;
      shift_dr   = 1'b0;
      shift_bits(32, 64'h0, d);
      n_tests++;
      if (d[31:0] !== ID_QONE) begin
         n_fail++;
         $display("FAIL cap_shift_same: got %h want %h", d[31:0], ID_QONE);
      end
   endtask

   task automatic test_update_read_probe();
      probe = 32'h12345678;
      tick();
      tick();
      do_capture(2'b01);
      update_dr = 1'b1;
      tick();
      update_dr = 1'b0;
      n_tests++;
      if (source !== 16'h3B06) begin
         n_fail++;
         $display("FAIL update_read_probe: source=%h want 3b06", source);
      end
   endtask

   task automatic test_recirculate();
      logic [63:0] d;
      do_capture(2'b00);
      shift_bits(32, 64'hCAFEF00D, d);
      shift_bits(32, 64'h0, d);
      n_tests++;
      if (d[31:0] !== 32'hCAFEF00D) begin
         n_fail++;
         $display("FAIL recirculate: got %h want cafef00d", d[31:0]);
      end
   endtask

   task automatic test_bypass();
      logic [63:0] d;
      do_capture(2'b11);
      n_tests++;
      if (tdo !== 1'b0) begin
         n_fail++;
         $display("FAIL bypass_capture: tdo=%b want 0", tdo);
      end
      shift_bits(4, 64'hB, d);
      n_tests++;
      if (d[3:0] !== 4'b0110 || tdo !== 1'b1) begin
         n_fail++;
         $display("FAIL bypass_shift: got %b/%b want 0110/1", d[3:0], tdo);
      end
   endtask

   task automatic test_reset_mid_shift();
      logic [63:0] d;
      do_capture(2'b00);
      shift_bits(10, 64'h0, d);
      rst_n = 1'b0;
      #1;
      n_tests++;
      if (tdo !== 1'b0 || source !== 16'h0) begin
         n_fail++;
         $display("FAIL reset_mid_shift: tdo=%b source=%h want 0/0000", tdo, source);
      end
      tick();
      rst_n = 1'b1;
      tick();
      do_capture(2'b00);
      shift_bits(32, 64'h0, d);
      n_tests++;
      if (d[31:0] !== ID_QONE) begin
         n_fail++;
         $display("FAIL reset_recapture: got %h want %h", d[31:0], ID_QONE);
      end
   endtask

   initial begin
      rst_n      = 1'b0;
      probe      = '0;
      sel        = 1'b1;
      ir_in      = 2'b00;
      capture_dr = 1'b0;
      shift_dr   = 1'b0;
      update_dr  = 1'b0;
      tdi        = 1'b0;
      test_reset();
      test_read_id();
      test_read_probe();
      test_write_source();
      test_sel_low();
      test_cap_shift_same();
      test_update_read_probe();
      test_recirculate();
      test_bypass();
      test_reset_mid_shift();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/debug_probe_wire.md
# debug_probe_wire

Debug probe/source register block for the fast-clock domain, where the PLL output drives the frequency/pulse logic. A scan chain reads a probe bus (e.g. live frequency settings) and a 32-bit instance tag, and writes an optional source bus. Models the virtual-wire debug endpoint in plain synchronous RTL, with no vendor JTAG primitive.

## Interface
Parameters:
- PROBE_WIDTH, 32: width of observed probe bus (1..64).
- WIDTH, 0: width of writable source bus; 0 = no source (port held 1 bit, constant 0).
- INSTANCE_ID, "NONE": 4 ASCII chars packed as 32 bits, first char in bits [31:24].

Ports:
- clk  in  1  single clock; every register in this domain.
- rst_n  in  1  reset, asynchronous and active-low.
- probe  in  PROBE_WIDTH  observed value.
- source  out  max(WIDTH,1)  written value.
- sel  in  1  instance selected; when low all scan controls are ignored.
- ir_in  in  2  instruction: 00 READ_ID, 01 READ_PROBE, 10 WRITE_SOURCE, 11 BYPASS.
- capture_dr  in  1  load data register.
- shift_dr  in  1  shift one bit.
- update_dr  in  1  commit data register.
- tdi  in  1  serial in.
- tdo  out  1  serial out.

## Operation
- probe_q <= probe every cycle (1-cycle sample register).
- Shift register sr is N = max(PROBE_WIDTH, WIDTH, 32) bits. ir_q latches ir_in on capture.
- Active length L by ir_q: READ_ID 32, READ_PROBE PROBE_WIDTH, WRITE_SOURCE max(WIDTH,1), BYPASS 1.
- capture_dr (sel=1) loads sr by ir_in; unused upper bits are cleared:
  - READ_ID: INSTANCE_ID.
  - READ_PROBE: probe_q, zero-extended.
  - WRITE_SOURCE: current source.
  - BYPASS: 0.
- shift_dr (sel=1): sr[L-2:0] <= sr[L-1:1], sr[L-1] <= tdi. Bits above L are untouched. LSB goes out first.
- update_dr (sel=1, ir_q=WRITE_SOURCE, WIDTH>0): source <= sr[WIDTH-1:0]. Otherwise update_dr is a no-op.
- Simultaneous controls: capture > shift > update; only the highest is acted on.
- tdo = sel ? sr[0] : 0 (combinational from register).
- Shifting past L bits recirculates tdi; there is no wrap to captured data.
- WIDTH=0: source is constant 0 and WRITE_SOURCE behaves as a 1-bit bypass.

## Timing
- Reset values: sr=0, ir_q=READ_ID, probe_q=0, source=0, tdo=0.
- Reset asserted mid-shift clears everything at once; after release, a capture is needed before valid data.
- Capture latency: sr is valid the cycle after capture_dr, and tdo shows bit 0 in that cycle.
- Each shift_dr cycle presents the next bit on tdo after the edge.
- The probe value captured is probe from 2 edges before the capture edge's result (probe_q lag).
- Source changes on the clock edge with update_dr and holds until the next update or reset.

## Structure
- Shared package dbg_wire_pkg holds:
  - instruction constants (IR_READ_ID, IR_READ_PROBE, IR_WRITE_SOURCE, IR_BYPASS);
  - the ID packing function (4 ASCII chars to 32 bits);
  - a max helper for widths.
- One natural sub-module, dbg_dr_chain: the parameterised capture/shift register with variable active length. The top keeps probe_q, ir_q and source.

## Test plan
- READ_ID, INSTANCE_ID="QONE": capture, then 32 shifts -> tdo LSB-first serialises 0x514F4E45; first bit 1.
- READ_PROBE, PROBE_WIDTH=32, probe=0x001D8340 held 2 cycles: capture + 32 shifts -> 0x001D8340. Probe changing after the capture edge is not reflected.
- WRITE_SOURCE, WIDTH=16: shift in 0x3B06 LSB-first, update_dr -> source=0x3B06. Next capture + shift-out returns 0x3B06.
- sel=0 with capture/shift/update pulses -> sr, source unchanged; tdo=0.
- capture_dr and shift_dr in the same cycle -> capture only.
- update_dr under READ_PROBE -> source unchanged.
- rst_n low after 10 of 32 shifts -> tdo=0 and source=0 immediately; a fresh READ_ID capture yields 0x514F4E45.
